// File: rtl/divider_pkg.sv
// Shared defaults and helpers for the multi-channel tick divider.
package divider_pkg;

    localparam int unsigned CNT_W_DEF       = 27;
    localparam int unsigned DEFAULT_DIV_DEF = 50000000;

    // What a channel does on the coming clock edge, highest priority first.
    typedef enum logic [1:0] {
        CH_SYNC = 2'd0,
        CH_IDLE = 2'd1,
        CH_RUN  = 2'd2,
        CH_HOLD = 2'd3
    } ch_mode_e;

    // Channel-index width: clog2 of the channel count, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_channel.sv
// One tick channel: active/shadow divisor pair, up-counter, registered
// tick pulse and 50 % level output.
module div_channel
    import divider_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_tick,
    output logic             o_level
);

    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             r_level;

    logic [CNT_W-1:0] w_shadow_nxt;
    logic [CNT_W-1:0] w_last;
    logic             w_wrap;
    ch_mode_e         w_mode;

    // Shadow as it will be after this edge; a same-cycle write is visible
    // to a wrap or sync, so the new divisor applies without delay.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (i_wr_en) begin
            w_shadow_nxt = i_wr_div;
        end
    end

    // Classify the cycle and find the wrap point; D-1 is only formed for
    // D>=1 so an idle channel never compares against an underflowed value.
    always_comb begin
        w_last = '0;
        w_mode = CH_HOLD;
        if (r_active != '0) begin
            w_last = r_active - CNT_W'(1);
        end
        if (i_sync) begin
            w_mode = CH_SYNC;
        end else if (r_active == '0) begin
            w_mode = CH_IDLE;
        end else if (i_en) begin
            w_mode = CH_RUN;
        end
        w_wrap = (w_mode == CH_RUN) && (r_count == w_last);
    end

    // Divisor, counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= CNT_W'(DEFAULT_DIV);
            r_shadow <= CNT_W'(DEFAULT_DIV);
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_level  <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            case (w_mode)
                CH_SYNC: begin
                    r_count  <= '0;
                    r_tick   <= 1'b0;
                    r_level  <= 1'b0;
                    r_active <= w_shadow_nxt;
                end
                CH_IDLE: begin
                    // Registered shadow, so a start write takes one extra cycle.
                    r_count  <= '0;
                    r_tick   <= 1'b0;
                    r_active <= r_shadow;
                end
                CH_RUN: begin
                    if (w_wrap) begin
                        r_count  <= '0;
                        r_tick   <= 1'b1;
                        r_level  <= ~r_level;
                        r_active <= w_shadow_nxt;
                    end else begin
                        r_count  <= r_count + CNT_W'(1);
                        r_tick   <= 1'b0;
                    end
                end
                default: begin
                    r_tick <= 1'b0;
                end
            endcase
        end
    end

    assign o_tick  = r_tick;
    assign o_level = r_level;

endmodule

// File: rtl/multi_tick_divider.sv
// Runtime-programmable multi-channel tick generator: decodes the divisor
// write port into per-channel strobes and replicates div_channel.
module multi_tick_divider
    import divider_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned CNT_W       = CNT_W_DEF,
    parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int unsigned CH_W        = idx_w(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_sync,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [CNT_W-1:0]  i_wr_div,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_level
);

    logic [NUM_CH-1:0] w_wr_sel;

    // One-hot write strobe; an index at or above NUM_CH selects nothing.
    always_comb begin
        w_wr_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (i_wr_en && (i_wr_ch == CH_W'(k))) begin
                w_wr_sel[k] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_en     (i_en[g]),
            .i_sync   (i_sync),
            .i_wr_en  (w_wr_sel[g]),
            .i_wr_div (i_wr_div),
            .o_tick   (o_tick[g]),
            .o_level  (o_level[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Bench for multi_tick_divider: a 4-channel and a 3-channel instance share
// stimulus; a countdown-style reference model predicts every output.
module tb_multi_tick_divider;

    localparam int unsigned NCH = 7;   // 0..3 -> instance A, 4..6 -> instance B
    localparam int unsigned DEF = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] en;
    logic       sync;
    logic       wr_en;
    logic [1:0] wr_ch_a;
    logic [1:0] wr_ch_b;
    logic [7:0] wr_div;
    logic [3:0] a_tick, a_level;
    logic [2:0] b_tick, b_level;

    always #5 clk = ~clk;

    multi_tick_divider #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(DEF)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync),
        .i_wr_en(wr_en), .i_wr_ch(wr_ch_a), .i_wr_div(wr_div),
        .o_tick(a_tick), .o_level(a_level)
    );

    multi_tick_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(DEF)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en[2:0]), .i_sync(sync),
        .i_wr_en(wr_en), .i_wr_ch(wr_ch_b), .i_wr_div(wr_div),
        .o_tick(b_tick), .o_level(b_level)
    );

    // Reference model: period in force, pending period, enabled cycles
    // left until the next tick, and the expected outputs.
    int unsigned m_per  [NCH];
    int unsigned m_pend [NCH];
    int unsigned m_left [NCH];
    logic [NCH-1:0] m_tk;
    logic [NCH-1:0] m_lv;

    int unsigned vectors;
    int unsigned miscompares;

    function automatic bit write_hits(input int k);
        if (k < 4) return wr_en && (int'(wr_ch_a) == k);
        return wr_en && (int'(wr_ch_b) == k - 4);
    endfunction

    function automatic bit en_of(input int k);
        return (k < 4) ? en[k] : en[k-4];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_per[k]  = DEF;
            m_pend[k] = DEF;
            m_left[k] = DEF;
        end
        m_tk = '0;
        m_lv = '0;
    endtask

    task automatic model_edge();
        int unsigned pn;
        for (int k = 0; k < NCH; k++) begin
            pn = write_hits(k) ? int'(wr_div) : m_pend[k];
            if (sync) begin
                m_per[k] = pn; m_left[k] = pn; m_tk[k] = 1'b0; m_lv[k] = 1'b0;
            end else if (m_per[k] == 0) begin
                m_tk[k] = 1'b0; m_per[k] = m_pend[k]; m_left[k] = m_pend[k];
            end else if (en_of(k)) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    m_tk[k] = 1'b1; m_lv[k] = ~m_lv[k];
                    m_per[k] = pn; m_left[k] = pn;
                end else begin
                    m_tk[k] = 1'b0;
                end
            end else begin
                m_tk[k] = 1'b0;
            end
            m_pend[k] = pn;
        end
    endtask

    task automatic check_outputs();
        logic [NCH-1:0] obs_t, obs_l;
        obs_t = {b_tick, a_tick};
        obs_l = {b_level, a_level};
        vectors++;
        assert (obs_t === m_tk) else begin
            miscompares++;
            $error("FAIL tick t=%0t observed=%b expected=%b", $time, obs_t, m_tk);
        end
        assert (obs_l === m_lv) else begin
            miscompares++;
            $error("FAIL level t=%0t observed=%b expected=%b", $time, obs_l, m_lv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Asserted away from any edge; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr_step(input int ch_a, input int ch_b, input int d);
        wr_en   = 1'b1;
        wr_ch_a = 2'(ch_a);
        wr_ch_b = 2'(ch_b);
        wr_div  = 8'(d);
        step();
        wr_en   = 1'b0;
        wr_ch_b = 2'd3;
    endtask

    initial begin
        bit found;
        vectors     = 0;
        miscompares = 0;
        en      = 4'hF;
        sync    = 1'b0;
        wr_en   = 1'b0;
        wr_ch_a = 2'd0;
        wr_ch_b = 2'd3;   // index 3 is out of range for the 3-channel instance
        wr_div  = 8'd0;
        do_reset();

        // Default period, shadow updates, write on a wrap, idle, restart, D=1.
        for (int c = 1; c <= 60; c++) begin
            case (c)
                7:       wr_step(1, 3, 3);
                19:      wr_step(1, 3, 2);
                20:      wr_step(0, 3, 6);
                22:      wr_step(2, 3, 0);
                35:      wr_step(2, 3, 4);
                45:      wr_step(3, 3, 1);
                default: step();
            endcase
        end

        // Enable pause on channel 0 for edges 4..13.
        do_reset();
        for (int c = 1; c <= 25; c++) begin
            en[0] = !(c >= 4 && c <= 13);
            step();
        end
        en = 4'hF;

        // Sync alignment with a simultaneous write.
        wr_step(0, 3, 3);
        wr_step(1, 3, 4);
        wr_step(2, 3, 5);
        wr_step(3, 3, 6);
        for (int c = 0; c < 30; c++) step();
        sync = 1'b1;
        wr_step(3, 3, 7);
        sync = 1'b0;
        for (int c = 0; c < 20; c++) step();

        // Asynchronous reset while a tick is high.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = (m_tk != '0);
        end
        if (!found) begin
            miscompares++;
            $display("FAIL tick_search observed=none expected=tick within 20 cycles");
        end
        do_reset();
        for (int c = 0; c < 12; c++) step();

        // Randomised traffic, including occasional mid-run resets.
        for (int c = 0; c < 400; c++) begin
            en      = 4'($urandom);
            sync    = ($urandom_range(0, 39) == 0);
            wr_en   = ($urandom_range(0, 4) == 0);
            wr_ch_a = 2'($urandom);
            wr_ch_b = 2'($urandom);
            wr_div  = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
